// File: rtl/lsu_frontend.sv
// Memory-stage front end: checks one load/store request, drives the LSU until it
// completes or times out, then returns an extended result or an exception to writeback.
module lsu_frontend #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        lsu_read_o,
  output logic        lsu_write_o,
  output logic [3:0]  lsu_we_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_data_o,
  input  logic [31:0] lsu_data_i,
  input  logic        lsu_valid_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic [1:0]  wb_exc_o,
  output logic [31:0] wb_addr_o,
  output logic [1:0]  dbg_state_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] EXC_OK       = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_e;

  state_e        state_q;
  logic          store_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt_q;
  logic          lsu_read_q, lsu_write_q;
  logic [3:0]    lsu_we_q;
  logic [31:0]   lsu_addr_q, lsu_data_q;
  logic          wb_valid_q, wb_we_q;
  logic [4:0]    wb_rd_q;
  logic [31:0]   wb_data_q, wb_addr_q;
  logic [1:0]    wb_exc_q;

  logic          illegal_c, misalign_c;
  logic [3:0]    we_c;
  logic [31:0]   sdata_c, ld_shift_c, ld_ext_c;

  // Both handshakes are valid/ready: a transfer happens on an edge where valid and
  // ready are both high; the producer holds valid and its payload stable until then.
  assign req_ready_o = (state_q == S_IDLE);
  assign lsu_read_o  = lsu_read_q;
  assign lsu_write_o = lsu_write_q;
  assign lsu_we_o    = lsu_we_q;
  assign lsu_addr_o  = lsu_addr_q;
  assign lsu_data_o  = lsu_data_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_we_o     = wb_we_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign wb_exc_o    = wb_exc_q;
  assign wb_addr_o   = wb_addr_q;
  assign dbg_state_o = state_q;

  always_comb begin
    illegal_c  = req_store_i ? (req_funct3_i > 3'd2)
                             : (req_funct3_i == 3'd3 || req_funct3_i == 3'd6 || req_funct3_i == 3'd7);
    misalign_c = (req_funct3_i[1:0] == 2'd1 && req_addr_i[0]) ||
                 (req_funct3_i[1:0] == 2'd2 && req_addr_i[1:0] != 2'd0);
    we_c    = 4'b0000;
    sdata_c = req_wdata_i;
    // Replicating the store value fills every lane, so the enabled lanes always hold
    // the correctly shifted bytes whatever the offset.
    case (req_funct3_i[1:0])
      2'd0: begin
        we_c    = 4'b0001 << req_addr_i[1:0];
        sdata_c = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        we_c    = 4'b0011 << req_addr_i[1:0];
        sdata_c = {2{req_wdata_i[15:0]}};
      end
      default: begin
        we_c    = 4'b1111;
        sdata_c = req_wdata_i;
      end
    endcase
    ld_shift_c = lsu_data_i >> {off_q, 3'b000};
    case (funct3_q)
      3'd0:    ld_ext_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      3'd4:    ld_ext_c = {24'd0, ld_shift_c[7:0]};
      3'd1:    ld_ext_c = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      3'd5:    ld_ext_c = {16'd0, ld_shift_c[15:0]};
      default: ld_ext_c = ld_shift_c;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      cnt_q       <= '0;
      lsu_read_q  <= 1'b0;
      lsu_write_q <= 1'b0;
      lsu_we_q    <= 4'd0;
      lsu_addr_q  <= 32'd0;
      lsu_data_q  <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      wb_exc_q    <= EXC_OK;
      wb_addr_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            store_q   <= req_store_i;
            funct3_q  <= req_funct3_i;
            off_q     <= req_addr_i[1:0];
            wb_addr_q <= req_addr_i;
            wb_rd_q   <= req_rd_i;
            wb_data_q <= 32'd0;
            wb_we_q   <= 1'b0;
            if (illegal_c) begin
              state_q    <= S_RESP;
              wb_valid_q <= 1'b1;
              wb_exc_q   <= EXC_ILLEGAL;
            end else if (misalign_c) begin
              state_q    <= S_RESP;
              wb_valid_q <= 1'b1;
              wb_exc_q   <= EXC_MISALIGN;
            end else begin
              state_q     <= S_ACCESS;
              cnt_q       <= '0;
              lsu_read_q  <= !req_store_i;
              lsu_write_q <= req_store_i;
              lsu_we_q    <= req_store_i ? we_c : 4'b0000;
              lsu_addr_q  <= {req_addr_i[31:2], 2'b00};
              lsu_data_q  <= req_store_i ? sdata_c : 32'd0;
            end
          end
        end
        S_ACCESS: begin
          // Completion is checked first so a strobe on the last counted cycle wins.
          if (lsu_valid_i) begin
            state_q     <= S_RESP;
            lsu_read_q  <= 1'b0;
            lsu_write_q <= 1'b0;
            wb_valid_q  <= 1'b1;
            wb_exc_q    <= EXC_OK;
            wb_data_q   <= store_q ? 32'd0 : ld_ext_c;
            wb_we_q     <= !store_q && (wb_rd_q != 5'd0);
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= S_RESP;
            lsu_read_q  <= 1'b0;
            lsu_write_q <= 1'b0;
            wb_valid_q  <= 1'b1;
            wb_exc_q    <= EXC_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (wb_ready_i) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_frontend.md
# lsu_frontend

Memory-stage controller that sits directly upstream of the load-store unit. It accepts one load/store request at a time from execute and checks alignment and `funct3`. It drives the LSU's read/write/byte-enable/address/data inputs until `valid` returns, then hands a sign- or zero-extended, lane-aligned result to writeback over a valid/ready handshake. Misaligned, illegal and timed-out accesses complete as exceptions without corrupting memory.

## Interface
- `TIMEOUT`, 256: maximum cycles spent in ACCESS before the access is aborted. Must be at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request from execute is present.
- `req_ready_o`  out  1  block can accept a request; high only in IDLE.
- `req_store_i`  in  1  1 = store, 0 = load.
- `req_funct3_i`  in  3  RV32I width code: LB 0, LH 1, LW 2, LBU 4, LHU 5, SB 0, SH 1, SW 2.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-justified.
- `req_rd_i`  in  5  destination register.
- `lsu_read_o`  out  1  load in progress, held until `lsu_valid_i`.
- `lsu_write_o`  out  1  store in progress, held until `lsu_valid_i`.
- `lsu_we_o`  out  4  byte enables; 0000 for loads.
- `lsu_addr_o`  out  32  word-aligned address `{addr[31:2], 2'b00}`.
- `lsu_data_o`  out  32  store data shifted to its byte lanes.
- `lsu_data_i`  in  32  raw load word from the LSU.
- `lsu_valid_i`  in  1  LSU completion strobe.
- `wb_valid_o`  out  1  result is present.
- `wb_ready_i`  in  1  writeback accepts the result.
- `wb_we_o`  out  1  register write: successful load with rd≠0.
- `wb_rd_o`  out  5  latched rd.
- `wb_data_o`  out  32  extended load data; 0 for stores and exceptions.
- `wb_exc_o`  out  2  00 ok, 01 misaligned, 10 illegal `funct3`, 11 timeout.
- `wb_addr_o`  out  32  latched request address, used as the trap value.

## Operation
- **FSM states:** IDLE, ACCESS, RESP. State and all registered outputs reset to IDLE/0.
- **IDLE:**
  - `req_ready_o`=1.
  - On `req_valid_i`, latch store, funct3, addr, wdata and rd.
  - Illegal funct3 goes to RESP with exc=10. Illegal means a load with funct3 in {3,6,7}, or a store with funct3>2.
  - Otherwise a misaligned access goes to RESP with exc=01. Misaligned means a half with addr[0]=1, or a word with addr[1:0]≠0.
  - Otherwise go to ACCESS, clear the timeout counter and drive the LSU outputs from the next cycle.
  - Illegal takes priority over misaligned.
- **ACCESS:**
  - `lsu_read_o`/`lsu_write_o` is held high. Address, we and data are stable for the whole phase.
  - Byte offset `off` = addr[1:0].
  - Store byte enables: SB `0001<<off`, SH `0011<<off`, SW `1111`.
  - Store data: `lsu_data_o = wdata << (8*off)`. The unused lanes carry replicated data.
  - On `lsu_valid_i`, deassert the LSU request in the same edge, latch the extracted load data and go to RESP with exc=00.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1, deassert the request and go to RESP with exc=11.
- **Load extraction:** take `lsu_data_i >> (8*off)`.
  - LB: sign-extend bit 7. LBU: zero-extend bit 7.
  - LH: sign-extend bit 15. LHU: zero-extend bit 15.
  - LW: pass through.
- **RESP:**
  - `wb_valid_o`=1. All wb fields are stable until `wb_ready_i`, then go to IDLE.
  - `wb_we_o` = !store & exc==00 & rd≠0.
- Only one transaction is in flight. There is no bypass from request to response.
- `lsu_read_o` and `lsu_write_o` are never high together.

## Timing
- **Reset values:** `req_ready_o`=1 (IDLE); all other outputs 0. Reset is honoured mid-ACCESS: LSU request lines drop immediately and asynchronously.
- **Cycle numbering:** request accepted at edge T.
  - ACCESS: LSU outputs are valid from T+1.
  - `lsu_valid_i` sampled high at edge T+k makes `wb_valid_o`=1 from T+k+1.
  - Exception path: `wb_valid_o`=1 from T+1; no LSU activity.
- **Throughput:** minimum 3 cycles per request (IDLE, ACCESS, RESP). With `wb_ready_i` tied high, back-to-back loads that have 1-cycle LSU latency complete every 3 cycles.
- **Spurious valid:** `lsu_valid_i` in IDLE or RESP is ignored.
- **Timeout:** `lsu_valid_i` arriving on the same edge as the timeout counter reaching TIMEOUT-1 counts as success.
- **Backpressure:** `wb_ready_i` low holds RESP indefinitely, and `req_ready_o` stays 0.

## Test plan
- **LB:** LB at 0x1003, LSU returns 0x80FF_1234 after 2 cycles. Expect `lsu_addr_o`=0x1000, we=0000, `wb_data_o`=0xFFFF_FF80, exc=00, `wb_we_o`=1. `wb_valid_o` rises 1 cycle after `lsu_valid_i`.
- **SH:** SH at 0x2002, wdata 0x0000_BEEF. Expect `lsu_write_o`=1, we=1100, `lsu_data_o`[31:16]=0xBEEF. Response has `wb_we_o`=0, exc=00.
- **Misaligned and illegal:** LW at 0x3001 gives exc=01 at T+1 with no `lsu_read_o` pulse. Load with funct3=3 at 0x3001 gives exc=10 (illegal wins).
- **Timeout:** with TIMEOUT=4, `lsu_valid_i` held low. `lsu_read_o` is high for exactly 4 cycles, then exc=11 with `wb_addr_o` equal to the request address.
- **Backpressure and spurious valid:** `wb_ready_i` low for 5 cycles during RESP. Output fields stay stable and `req_ready_o`=0. A spurious `lsu_valid_i` in RESP changes nothing.
- **Reset mid-ACCESS:** assert `rstn_i`=0 during ACCESS. `lsu_read_o`, `wb_valid_o` and `wb_exc_o` go to 0 immediately and `req_ready_o` goes to 1. After release, an LW to 0x0 completes normally.
